// File: rtl/sar_conv_host.sv
// Host-side controller for a SAR conversion block: issues cnvst pulses (single-shot or periodic),
// captures the result on the eoc rising edge into a one-deep valid/ready register, flags timeouts and overruns.
module sar_conv_host #(
   parameter int N_BITS       = 10,
   parameter int CNVST_CYCLES = 2,
   parameter int TIMEOUT      = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              cont_en,
   input  logic [7:0]        interval,
   output logic              cnvst,
   input  logic              eoc,
   input  logic [N_BITS-1:0] sar,
   output logic [N_BITS-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              busy,
   output logic              timeout_err,
   output logic              overrun
);

   localparam int PW = (CNVST_CYCLES > 1) ? $clog2(CNVST_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, PULSE, WAIT_EOC, CAPTURE, GAP} state_t;

   state_t            state_reg, state_next;
   logic [PW-1:0]     pulse_cnt_reg, pulse_cnt_next;
   logic [TW-1:0]     to_cnt_reg, to_cnt_next;
   logic [7:0]        gap_cnt_reg, gap_cnt_next;
   logic [7:0]        gap_len_reg, gap_len_next;
   logic              armed_reg, armed_next;
   logic              cont_blk_reg, cont_blk_next;
   logic              eoc_q;
   logic              cnvst_reg;
   logic [N_BITS-1:0] sar_hold_reg;
   logic [N_BITS-1:0] dout_reg;
   logic              dout_valid_reg;
   logic              timeout_err_reg;
   logic              overrun_reg;

   logic eoc_rise;
   logic launch;
   logic timeout_set;
   logic capture;
   logic detect;

   assign eoc_rise = eoc & ~eoc_q;

   always_comb begin
      state_next     = state_reg;
      pulse_cnt_next = pulse_cnt_reg;
      to_cnt_next    = to_cnt_reg;
      gap_cnt_next   = gap_cnt_reg;
      gap_len_next   = gap_len_reg;
      armed_next     = armed_reg;
      cont_blk_next  = cont_blk_reg;
      launch         = 1'b0;
      timeout_set    = 1'b0;
      capture        = 1'b0;
      detect         = 1'b0;

      case (state_reg)
         IDLE: begin
            to_cnt_next = '0;
            // After a timeout, continuous mode stays parked until an explicit start.
            if (start || (cont_en && !cont_blk_reg)) begin
               state_next = PULSE;
               launch     = 1'b1;
               if (start) cont_blk_next = 1'b0;
            end
         end
         PULSE: begin
            to_cnt_next = to_cnt_reg + 1'b1;
            if (!eoc) armed_next = 1'b1;
            if (pulse_cnt_reg == PW'(CNVST_CYCLES - 1)) state_next = WAIT_EOC;
            else pulse_cnt_next = pulse_cnt_reg + 1'b1;
         end
         WAIT_EOC: begin
            if (!eoc) armed_next = 1'b1;
            if (eoc_rise && armed_reg) begin
               state_next = CAPTURE;
               detect     = 1'b1;
            end else if (to_cnt_reg == TW'(TIMEOUT - 1)) begin
               state_next    = IDLE;
               timeout_set   = 1'b1;
               cont_blk_next = 1'b1;
            end else begin
               to_cnt_next = to_cnt_reg + 1'b1;
            end
         end
         CAPTURE: begin
            capture = 1'b1;
            if (cont_en) begin
               if (interval != 8'd0) begin
                  state_next   = GAP;
                  gap_len_next = interval;
                  gap_cnt_next = '0;
               end else begin
                  state_next = PULSE;
               end
            end else begin
               state_next = IDLE;
            end
         end
         GAP: begin
            if (!cont_en) state_next = IDLE;
            else if (gap_cnt_reg == 8'(gap_len_reg - 8'd1)) state_next = PULSE;
            else gap_cnt_next = gap_cnt_reg + 8'd1;
         end
         default: state_next = IDLE;
      endcase

      // Every entry into PULSE starts a fresh conversion window.
      if (state_next == PULSE && state_reg != PULSE) begin
         pulse_cnt_next = '0;
         to_cnt_next    = '0;
         armed_next     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= IDLE;
         pulse_cnt_reg   <= '0;
         to_cnt_reg      <= '0;
         gap_cnt_reg     <= '0;
         gap_len_reg     <= '0;
         armed_reg       <= 1'b0;
         cont_blk_reg    <= 1'b0;
         eoc_q           <= 1'b0;
         cnvst_reg       <= 1'b0;
         sar_hold_reg    <= '0;
         dout_reg        <= '0;
         dout_valid_reg  <= 1'b0;
         timeout_err_reg <= 1'b0;
         overrun_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pulse_cnt_reg <= pulse_cnt_next;
         to_cnt_reg    <= to_cnt_next;
         gap_cnt_reg   <= gap_cnt_next;
         gap_len_reg   <= gap_len_next;
         armed_reg     <= armed_next;
         cont_blk_reg  <= cont_blk_next;
         eoc_q         <= eoc;
         cnvst_reg     <= (state_next == PULSE);
         // sar is sampled while eoc is known high, then loaded in CAPTURE.
         if (detect) sar_hold_reg <= sar;
         if (capture) dout_reg <= sar_hold_reg;

         if (capture) dout_valid_reg <= 1'b1;
         else if (dout_valid_reg && dout_ready) dout_valid_reg <= 1'b0;

         if (launch) overrun_reg <= 1'b0;
         else if (capture && dout_valid_reg && !dout_ready) overrun_reg <= 1'b1;

         if (launch) timeout_err_reg <= 1'b0;
         else if (timeout_set) timeout_err_reg <= 1'b1;
      end
   end

   assign cnvst       = cnvst_reg;
   assign dout        = dout_reg;
   assign dout_valid  = dout_valid_reg;
   assign busy        = (state_reg != IDLE);
   assign timeout_err = timeout_err_reg;
   assign overrun     = overrun_reg;

endmodule

// File: tb/tb_sar_conv_host.sv
// Bench for sar_conv_host: a cycle-level SAR responder plus event logs, checked against timing rules
// (start->cnvst, eoc->dout_valid, gap spacing, timeout) and a result queue.
module tb_sar_conv_host;

   localparam int N  = 10;
   localparam int TO = 64;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         cont_en = 1'b0;
   logic [7:0]   interval = 8'd0;
   logic         eoc = 1'b0;
   logic [N-1:0] sar = '0;
   logic         dout_ready = 1'b0;
   logic         cnvst, dout_valid, busy, timeout_err, overrun;
   logic [N-1:0] dout;

   always #5 clk = ~clk;

   sar_conv_host #(.N_BITS(N), .CNVST_CYCLES(2), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .cont_en(cont_en), .interval(interval),
      .cnvst(cnvst), .eoc(eoc), .sar(sar), .dout(dout), .dout_valid(dout_valid),
      .dout_ready(dout_ready), .busy(busy), .timeout_err(timeout_err), .overrun(overrun)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // SAR responder and event logs
   bit sar_en = 1'b1;
   bit manual = 1'b0;
   int sar_delay = 14;
   int sar_hold = 4;
   int code_q[$];
   int rise_q[$], width_q[$], eoc_log[$], dv_q[$], pop_q[$];
   bit cn_prev = 1'b0, dv_prev = 1'b0, raised;
   int cd = 0, hold = 0, w = 0;

   initial begin : sar_model
      forever begin
         @(posedge clk); #2;
         raised = 1'b0;
         if (dout_valid && dout_ready) pop_q.push_back(int'(dout));
         if (dout_valid && !dv_prev) dv_q.push_back(cyc);
         dv_prev = dout_valid;
         if (cnvst && !cn_prev) begin
            rise_q.push_back(cyc);
            w  = 1;
            cd = sar_en ? sar_delay : 0;
         end else begin
            if (cnvst) w++;
            else if (cn_prev) width_q.push_back(w);
            if (cd > 0) begin
               cd--;
               if (cd == 0 && !manual) begin
                  eoc    = 1'b1;
                  sar    = (code_q.size() > 0) ? N'(code_q.pop_front()) : N'($urandom);
                  eoc_log.push_back(cyc);
                  hold   = sar_hold;
                  raised = 1'b1;
               end
            end
         end
         if (!manual && !raised && eoc) begin
            if (hold > 0) hold--;
            if (hold == 0) eoc = 1'b0;
         end
         cn_prev = cnvst;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no finish, expected finish within 50000 cycles");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic clear_logs();
      rise_q.delete(); width_q.delete(); eoc_log.delete(); dv_q.delete(); pop_q.delete();
   endtask

   task automatic wait_dv(input int max, output int t);
      t = -1;
      for (int i = 0; i < max; i++) begin
         if (dout_valid) begin t = cyc; break; end
         tick();
      end
      if (t < 0) chk("wait_dout_valid_bound", 0, 1);
   endtask

   task automatic wait_idle(input int max);
      int ok;
      ok = 0;
      for (int i = 0; i < max; i++) begin
         if (!busy) begin ok = 1; break; end
         tick();
      end
      if (ok == 0) chk("wait_idle_bound", 0, 1);
   endtask

   task automatic pop();
      dout_ready = 1'b1; tick(); dout_ready = 1'b0;
   endtask

   task automatic wait_eocs(input int n, input int max);
      int ok;
      ok = 0;
      for (int i = 0; i < max; i++) begin
         if (eoc_log.size() >= n) begin ok = 1; break; end
         tick();
      end
      if (ok == 0) chk("wait_eoc_bound", eoc_log.size(), n);
   endtask

   typedef struct {
      int delay;
      int hold;
      int code;
      int rdy_wait;
      int exp_dout;
      int exp_width;
   } vec_t;

   vec_t vecs[$];
   int   s, t, iv, code;
   int   exp_codes[$];

   initial begin : main
      vecs.push_back('{14, 4, 'h2A5, 0, 'h2A5, 2});
      vecs.push_back('{2, 1, 'h000, 3, 'h000, 2});
      vecs.push_back('{62, 3, 'h3FF, 1, 'h3FF, 2});
      vecs.push_back('{5, 10, 'h155, 2, 'h155, 2});
      for (int i = 0; i < 4; i++) begin
         code = int'($urandom_range(0, 1023));
         vecs.push_back('{int'($urandom_range(2, 50)), int'($urandom_range(1, 6)), code,
                          int'($urandom_range(0, 4)), code, 2});
      end

      // reset values while held in reset
      repeat (3) tick();
      chk("rst_cnvst", cnvst, 0);
      chk("rst_dout", dout, 0);
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_overrun", overrun, 0);
      #3 rst = 1'b1;
      repeat (2) tick();

      // table-driven single shots
      foreach (vecs[k]) begin
         wait_idle(200);
         clear_logs();
         sar_delay = vecs[k].delay;
         sar_hold  = vecs[k].hold;
         code_q.push_back(vecs[k].code);
         start = 1'b1; s = cyc; tick(); start = 1'b0;
         chk("ss_busy_after_start", busy, 1);
         chk("ss_cnvst_after_start", cnvst, 1);
         wait_dv(150, t);
         if (rise_q.size() > 0) chk("ss_cnvst_rise_cycle", rise_q[0], s + 1);
         else chk("ss_cnvst_rise_seen", 0, 1);
         if (width_q.size() > 0) chk("ss_cnvst_width", width_q[0], vecs[k].exp_width);
         else chk("ss_cnvst_width_seen", 0, 1);
         if (eoc_log.size() > 0) chk("ss_dv_latency", t, eoc_log[0] + 2);
         else chk("ss_eoc_seen", 0, 1);
         chk("ss_dout", dout, vecs[k].exp_dout);
         chk("ss_busy_done", busy, 0);
         chk("ss_timeout_err", timeout_err, 0);
         repeat (vecs[k].rdy_wait) tick();
         chk("ss_dv_held", dout_valid, 1);
         pop();
         chk("ss_dv_cleared", dout_valid, 0);
         chk("ss_dout_after_pop", dout, vecs[k].exp_dout);
      end

      // continuous: fixed interval 5 with codes 1,2,3, then two randomized runs
      for (int r = 0; r < 3; r++) begin
         wait_idle(200);
         clear_logs();
         exp_codes.delete();
         if (r == 0) begin
            iv = 5; sar_delay = 14; sar_hold = 4;
            exp_codes = '{1, 2, 3};
         end else begin
            iv = int'($urandom_range(0, 7));
            sar_delay = int'($urandom_range(8, 40));
            sar_hold  = int'($urandom_range(1, 4));
            for (int i = 0; i < 4; i++) exp_codes.push_back(int'($urandom_range(0, 1023)));
         end
         code_q = exp_codes;
         interval = 8'(iv);
         dout_ready = 1'b1;
         cont_en = 1'b1;
         wait_eocs(exp_codes.size(), 1000);
         cont_en = 1'b0;
         wait_idle(50);
         repeat (3) tick();
         dout_ready = 1'b0;
         chk("cont_pop_count", pop_q.size(), exp_codes.size());
         foreach (exp_codes[i])
            if (i < pop_q.size()) chk("cont_code", pop_q[i], exp_codes[i]);
         for (int i = 0; i + 1 < exp_codes.size(); i++)
            if (i + 1 < rise_q.size() && i < eoc_log.size())
               chk("cont_gap_spacing", rise_q[i+1], eoc_log[i] + 2 + iv);
         chk("cont_no_overrun", overrun, 0);
      end

      // overrun: back-to-back conversions with consumer stalled
      wait_idle(200);
      clear_logs();
      sar_delay = 10; sar_hold = 4;
      code_q = '{'h111, 'h222};
      interval = 8'd0; dout_ready = 1'b0; cont_en = 1'b1;
      wait_eocs(2, 500);
      cont_en = 1'b0;
      wait_idle(50);
      tick();
      chk("ovr_flag", overrun, 1);
      chk("ovr_dout_second", dout, 'h222);
      chk("ovr_dv", dout_valid, 1);
      repeat (4) tick();
      pop();
      chk("ovr_sticky", overrun, 1);
      chk("ovr_popped", dout_valid, 0);
      code_q.push_back('h0AB);
      start = 1'b1; tick(); start = 1'b0;
      chk("ovr_cleared_on_start", overrun, 0);
      wait_dv(150, t);
      chk("ovr_next_dout", dout, 'h0AB);

      // timeout with an unread result pending and cont_en raised mid-conversion
      wait_idle(50);
      clear_logs();
      sar_en = 1'b0;
      start = 1'b1; s = cyc; tick(); start = 1'b0;
      cont_en = 1'b1;
      while (cyc < s + TO) tick();
      chk("to_not_yet", timeout_err, 0);
      chk("to_busy_before", busy, 1);
      tick();
      chk("to_flag", timeout_err, 1);
      chk("to_idle", busy, 0);
      chk("to_dv_unchanged", dout_valid, 1);
      chk("to_dout_unchanged", dout, 'h0AB);
      repeat (5) tick();
      chk("to_cont_ignored", busy, 0);
      chk("to_sticky", timeout_err, 1);
      cont_en = 1'b0; sar_en = 1'b1;
      pop();
      sar_delay = 14; sar_hold = 4;
      code_q.push_back('h2C4);
      start = 1'b1; tick(); start = 1'b0;
      chk("to_cleared_on_start", timeout_err, 0);
      wait_dv(150, t);
      chk("to_recover_dout", dout, 'h2C4);
      pop();

      // stale eoc held high through PULSE, capture only on the re-rise
      wait_idle(50);
      manual = 1'b1;
      eoc = 1'b1; sar = 10'h3C3;
      repeat (2) tick();
      start = 1'b1; s = cyc; tick(); start = 1'b0;
      while (cyc < s + 5) tick();
      eoc = 1'b0;
      while (cyc < s + 7) tick();
      chk("stale_no_capture", dout_valid, 0);
      chk("stale_still_busy", busy, 1);
      tick();
      eoc = 1'b1; sar = 10'h1E1;
      tick();
      chk("stale_dv_not_yet", dout_valid, 0);
      tick();
      chk("stale_dv", dout_valid, 1);
      chk("stale_dout", dout, 'h1E1);
      eoc = 1'b0; manual = 1'b0;
      pop();

      // async reset mid-WAIT_EOC with an unread result present
      wait_idle(50);
      code_q.push_back('h2F0);
      start = 1'b1; tick(); start = 1'b0;
      wait_dv(150, t);
      clear_logs();
      sar_delay = 30;
      start = 1'b1; s = cyc; tick(); start = 1'b0;
      while (cyc < s + 10) tick();
      #2 rst = 1'b0;
      #1;
      chk("arst_busy_immediate", busy, 0);
      chk("arst_cnvst_immediate", cnvst, 0);
      chk("arst_dv_immediate", dout_valid, 0);
      chk("arst_dout_immediate", dout, 0);
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      repeat (30) tick();
      chk("arst_result_discarded", dout_valid, 0);
      chk("arst_idle", busy, 0);
      // reset during PULSE drops cnvst without waiting for a clock
      start = 1'b1; tick(); start = 1'b0;
      chk("arst_pulse_cnvst_high", cnvst, 1);
      #2 rst = 1'b0;
      #1;
      chk("arst_pulse_cnvst_drop", cnvst, 0);
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      repeat (40) tick();
      sar_delay = 14;
      clear_logs();
      code_q.delete();
      code_q.push_back('h0F0);
      start = 1'b1; s = cyc; tick(); start = 1'b0;
      wait_dv(150, t);
      if (rise_q.size() > 0) chk("arst_restart_rise", rise_q[0], s + 1);
      else chk("arst_restart_rise_seen", 0, 1);
      chk("arst_restart_dout", dout, 'h0F0);
      pop();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sar_conv_host.md
Name: sar_conv_host

Overview:
Host-side conversion controller for the 10-bit charge-sharing SAR logic block. It issues cnvst pulses (single-shot or periodic) and watches for eoc. At end of conversion it captures the sar code into a one-deep output register with a valid/ready handshake. It also flags conversion timeouts and overruns of unread results.

Parameters:
N_BITS, 10, width of sar / dout
CNVST_CYCLES, 2, cnvst high width in clk cycles (>=1)
TIMEOUT, 64, max cycles from cnvst rise to eoc rise before timeout_err (>=N_BITS+2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset (rst=0 resets)
start  input  1  request one conversion; sampled in IDLE only
cont_en  input  1  continuous mode: re-trigger after gap while high
interval  input  8  idle gap in cycles between conversions in continuous mode (0 = back-to-back)
cnvst  output  1  conversion start to SAR logic, registered
eoc  input  1  end of conversion from SAR logic, same clock domain
sar  input  N_BITS  conversion result from SAR logic, valid while eoc high
dout  output  N_BITS  captured result
dout_valid  output  1  dout holds an unread result
dout_ready  input  1  consumer accepts dout when dout_valid=1
busy  output  1  high in any state except IDLE
timeout_err  output  1  sticky: eoc rise not seen within TIMEOUT cycles
overrun  output  1  sticky: unread result overwritten

Behaviour:
- Reset (async, rst=0): state=IDLE, cnvst=0, dout=0, dout_valid=0, busy=0, timeout_err=0, overrun=0, counters=0, eoc_q=0.
- eoc_q is a 1-cycle registered copy of eoc. eoc_rise = eoc & ~eoc_q.
- FSM states: IDLE, PULSE, WAIT_EOC, CAPTURE, GAP.
- IDLE:
  - start=1 or cont_en=1 -> PULSE.
  - cnvst is driven 1 from the next cycle.
  - Timeout counter cleared.
  - timeout_err and overrun are cleared on this transition.
- PULSE:
  - cnvst=1 for exactly CNVST_CYCLES cycles, then -> WAIT_EOC with cnvst=0.
  - An eoc_rise during PULSE is ignored; the previous conversion's eoc may still be high.
- WAIT_EOC:
  - An armed flag is set once eoc=0 has been sampled in PULSE or WAIT_EOC.
  - eoc_rise while armed -> CAPTURE.
  - Timeout counter runs from the first PULSE cycle. If it reaches TIMEOUT -> set timeout_err and go to IDLE. cont_en is ignored until the next start. dout is unchanged.
- CAPTURE (1 cycle):
  - dout <= sar and dout_valid <= 1.
  - If dout_valid=1 and dout_ready=0 in this cycle, set overrun=1. The old data is lost.
  - If dout_valid=1 and dout_ready=1 in the same cycle, the pop and load coincide: dout_valid stays 1 and no overrun.
  - Next state: -> GAP if cont_en=1 and interval>0; -> PULSE if cont_en=1 and interval=0; else -> IDLE.
- GAP:
  - Counts interval cycles, then -> PULSE.
  - cont_en dropping to 0 during GAP -> IDLE at the next edge.
- Handshake: dout_valid clears on any cycle with dout_valid=1 and dout_ready=1, except a coinciding CAPTURE. dout holds its value after the pop.
- Latency: start sampled at edge t gives cnvst=1 at t+1 .. t+CNVST_CYCLES. dout_valid=1 one cycle after the edge where eoc_rise is detected.
- start asserted while busy is ignored and not queued.
- Changing interval mid-GAP has no effect on the current gap; the value is latched on entering GAP.
- Reset mid-conversion: cnvst drops to 0 immediately (async). The captured result is discarded.

Test Plan:
- Single shot: rst released, start=1 for 1 cycle. A SAR model raises eoc 14 cycles after the cnvst rise with sar=10'h2A5 -> cnvst high for exactly 2 cycles; dout=10'h2A5 and dout_valid=1 one cycle after the eoc rise; busy returns to 0; dout_ready=1 clears dout_valid.
- Continuous: cont_en=1, interval=5, model returns codes 1,2,3 -> three conversions, each cnvst rise 1+5 cycles after the previous CAPTURE, dout_ready held 1. Received sequence is 1,2,3 with no overrun.
- Overrun: cont_en=1, interval=0, dout_ready=0 -> second CAPTURE sets overrun=1 and dout equals the second code. overrun stays 1 until the next IDLE->PULSE.
- Timeout: start with a model that never asserts eoc -> timeout_err=1 exactly TIMEOUT=64 cycles after the first PULSE cycle; FSM in IDLE; dout_valid unchanged.
- Stale eoc: eoc held high from the previous conversion through PULSE, then dropped and re-raised -> capture only on the re-rise, never on the held-high level.
- Async reset mid-WAIT_EOC: rst=0 for 3 cycles -> cnvst=0 immediately, all outputs at reset values; a subsequent start works normally.
